// File: rtl/mux_pkg.sv
// Shared definitions for the registered round-robin multiplexer.
// Holds the select-mode encodings and a clog2 helper that never returns 0.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for an n-entry select; one bit minimum so ports stay legal.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found searching upward from ptr+1, wrapping modulo N.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant
);

    int  idx;
    logic found;

    // Visiting offsets 1..N gives rotate, priority pick and unrotate in one pass.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_reg.sv
// Registered N:1 valid/ready multiplexer with fixed-select and round-robin
// modes; one output register gives one cycle of latency at full throughput.
module mux_rr_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SELW     = clog2_min1(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] I_data,
    input  logic [CHANNELS-1:0]       I_valid,
    output logic [CHANNELS-1:0]       I_ready,
    input  logic                      mode,
    input  logic [SELW-1:0]           select,
    output logic [WIDTH-1:0]          Y,
    output logic                      Y_valid,
    input  logic                      Y_ready,
    output logic [SELW-1:0]           Y_sel
);

    logic [SELW-1:0]     ptr;
    logic [CHANNELS-1:0] grant_rr;
    logic [CHANNELS-1:0] grant_fixed;
    logic [CHANNELS-1:0] grant;
    logic [WIDTH-1:0]    grant_data;
    logic [SELW-1:0]     grant_idx;
    logic                load_en;

    rr_arbiter #(
        .N    (CHANNELS),
        .SELW (SELW)
    ) u_arbiter (
        .req   (I_valid),
        .ptr   (ptr),
        .grant (grant_rr)
    );

    // A select value beyond the last channel matches no index and grants nothing.
    always_comb begin
        grant_fixed = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            grant_fixed[i] = I_valid[i] && (select == SELW'(i));
        end
    end

    assign grant   = (mode == MODE_RR) ? grant_rr : grant_fixed;
    assign load_en = !Y_valid || Y_ready;
    assign I_ready = grant & {CHANNELS{load_en}};

    always_comb begin
        grant_data = '0;
        grant_idx  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            grant_data = grant_data | (I_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
            if (grant[i]) begin
                grant_idx = SELW'(i);
            end
        end
    end

    // ptr resets to the last channel so that channel 0 wins the first search.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y       <= '0;
            Y_sel   <= '0;
            Y_valid <= 1'b0;
            ptr     <= SELW'(CHANNELS - 1);
        end else if (load_en) begin
            if (|grant) begin
                Y       <= grant_data;
                Y_sel   <= grant_idx;
                Y_valid <= 1'b1;
                if (mode == MODE_RR) begin
                    ptr <= grant_idx;
                end
            end else begin
                Y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed self-checking bench for mux_rr_reg with WIDTH=8, CHANNELS=4;
// expected values are hand-derived from the handshake and arbitration rules.
module tb_mux_rr_reg;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int SELW     = 2;

    logic                      clk;
    logic                      rst;
    logic [CHANNELS*WIDTH-1:0] i_data;
    logic [CHANNELS-1:0]       i_valid;
    logic [CHANNELS-1:0]       i_ready;
    logic                      mode;
    logic [SELW-1:0]           select;
    logic [WIDTH-1:0]          y;
    logic                      y_valid;
    logic                      y_ready;
    logic [SELW-1:0]           y_sel;

    int vector_count = 0;
    int miss_count   = 0;

    logic [7:0] chan_byte [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    mux_rr_reg #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .I_data  (i_data),
        .I_valid (i_valid),
        .I_ready (i_ready),
        .mode    (mode),
        .select  (select),
        .Y       (y),
        .Y_valid (y_valid),
        .Y_ready (y_ready),
        .Y_sel   (y_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data,
                                 input logic md, input logic [1:0] sel, input logic rdy);
        i_valid = valid;
        i_data  = data;
        mode    = md;
        select  = sel;
        y_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = '0;
        i_data  = '0;
        mode    = 1'b0;
        select  = '0;
        y_ready = 1'b0;
        #12;
        checkOutput("reset_y", 32'(y), 32'h00);
        checkOutput("reset_sel", 32'(y_sel), 32'd0);
        checkOutput("reset_valid", 32'(y_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        checkOutput("post_reset_valid", 32'(y_valid), 32'd0);
        checkOutput("post_reset_y", 32'(y), 32'h00);

        // Fixed select of channel 2 with everything valid
        applyStimulus(4'b1111, 32'h44332211, 1'b0, 2'd2, 1'b1);
        checkOutput("fixed_ready_0", 32'(i_ready), 32'b0100);
        tick();
        checkOutput("fixed_y", 32'(y), 32'h33);
        checkOutput("fixed_sel", 32'(y_sel), 32'd2);
        checkOutput("fixed_valid", 32'(y_valid), 32'd1);
        for (int k = 0; k < 2; k++) begin
            checkOutput("fixed_ready_n", 32'(i_ready), 32'b0100);
            tick();
        end

        // Round-robin over all four channels, starting from channel 0
        applyStimulus(4'b1111, 32'h44332211, 1'b1, 2'd2, 1'b1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("rr_ready", 32'(i_ready), 32'(1 << (k % 4)));
            tick();
            checkOutput("rr_sel", 32'(y_sel), 32'(k % 4));
            checkOutput("rr_y", 32'(y), 32'(chan_byte[k % 4]));
            checkOutput("rr_valid", 32'(y_valid), 32'd1);
        end

        // Two requesters alternate, then a single requester streams
        applyStimulus(4'b1010, 32'h44332211, 1'b1, 2'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("rr_alt_sel", 32'(y_sel), (k % 2 == 0) ? 32'd1 : 32'd3);
            checkOutput("rr_alt_valid", 32'(y_valid), 32'd1);
        end
        applyStimulus(4'b1000, 32'h44332211, 1'b1, 2'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("single_ready", 32'(i_ready), 32'b1000);
            tick();
            checkOutput("single_sel", 32'(y_sel), 32'd3);
            checkOutput("single_valid", 32'(y_valid), 32'd1);
        end

        // Drain, then hold 0x5A under back-pressure
        applyStimulus(4'b0000, 32'h44332211, 1'b1, 2'd0, 1'b1);
        tick();
        checkOutput("drain_valid", 32'(y_valid), 32'd0);
        checkOutput("drain_y_hold", 32'(y), 32'h44);
        applyStimulus(4'b0001, 32'h0000005A, 1'b0, 2'd0, 1'b0);
        checkOutput("bp_load_ready", 32'(i_ready), 32'b0001);
        tick();
        checkOutput("bp_y", 32'(y), 32'h5A);
        applyStimulus(4'b0001, 32'h000000A5, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("bp_ready", 32'(i_ready), 32'b0000);
            tick();
            checkOutput("bp_hold_y", 32'(y), 32'h5A);
            checkOutput("bp_hold_valid", 32'(y_valid), 32'd1);
        end
        applyStimulus(4'b0001, 32'h000000A5, 1'b0, 2'd0, 1'b1);
        checkOutput("bp_release_ready", 32'(i_ready), 32'b0001);
        tick();
        checkOutput("bp_new_y", 32'(y), 32'hA5);
        checkOutput("bp_new_valid", 32'(y_valid), 32'd1);

        // Fixed select of an idle channel grants nothing
        applyStimulus(4'b1101, 32'h44332211, 1'b0, 2'd1, 1'b1);
        checkOutput("idle_sel_ready", 32'(i_ready), 32'b0000);
        tick();
        checkOutput("idle_sel_valid", 32'(y_valid), 32'd0);
        checkOutput("idle_sel_y_hold", 32'(y), 32'hA5);

        // Round-robin resumes after the last RR grant (channel 3)
        applyStimulus(4'b1101, 32'h44332211, 1'b1, 2'd1, 1'b1);
        checkOutput("resume_ready", 32'(i_ready), 32'b0001);
        tick();
        checkOutput("resume_sel0", 32'(y_sel), 32'd0);
        tick();
        checkOutput("resume_sel1", 32'(y_sel), 32'd2);
        tick();
        checkOutput("resume_sel2", 32'(y_sel), 32'd3);
        checkOutput("resume_valid", 32'(y_valid), 32'd1);

        // Asynchronous reset in the middle of a stream
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(y_valid), 32'd0);
        checkOutput("async_rst_y", 32'(y), 32'h00);
        checkOutput("async_rst_sel", 32'(y_sel), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(4'b1111, 32'h44332211, 1'b1, 2'd0, 1'b1);
        checkOutput("ptr_after_rst_ready", 32'(i_ready), 32'b0001);
        tick();
        checkOutput("ptr_after_rst_sel", 32'(y_sel), 32'd0);
        checkOutput("ptr_after_rst_y", 32'(y), 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
